// File: rtl/issue_age_tracker.sv
// ============================================================================
// Module   : issue_age_tracker
// Brief    : Issue-queue entry tracker with saturating per-entry ages and
//            wakeup/select handling. Define ISSUE_AGE_TRACKER_ERROR_CHECK_EN
//            to add a sticky protocol error output (error_out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_age_tracker #(
    parameter int NUM_ENTRIES                  = 8,
    parameter int ENTRY_PTR_SIZE_IN_BITS       = 3,
    parameter int SINGLE_ELEMENT_WIDTH_IN_BITS = 3
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic                                                flush_in,
    input  logic                                                alloc_valid_in,
    output logic                                                alloc_ready_out,
    output logic [ENTRY_PTR_SIZE_IN_BITS-1:0]                   alloc_ptr_out,
    input  logic [NUM_ENTRIES-1:0]                              wakeup_in,
    input  logic                                                select_valid_in,
    input  logic [ENTRY_PTR_SIZE_IN_BITS-1:0]                   select_ptr_in,
    output logic [NUM_ENTRIES-1:0]                              condition_out,
    output logic [SINGLE_ELEMENT_WIDTH_IN_BITS*NUM_ENTRIES-1:0] elements_out,
    output logic [ENTRY_PTR_SIZE_IN_BITS:0]                     occupancy_out
`ifdef ISSUE_AGE_TRACKER_ERROR_CHECK_EN
    ,
    output logic                                                error_out
`endif
);

    localparam int                          c_W          = SINGLE_ELEMENT_WIDTH_IN_BITS;
    localparam int                          c_P          = ENTRY_PTR_SIZE_IN_BITS;
    localparam logic [c_P:0]                c_FULL_COUNT = (c_P+1)'(NUM_ENTRIES);
    localparam logic [c_W-1:0]              c_AGE_MAX    = {c_W{1'b1}};

    logic [NUM_ENTRIES-1:0]     r_valid;
    logic [NUM_ENTRIES-1:0]     r_woken;
    logic [NUM_ENTRIES-1:0]     r_cond;
    logic [c_W*NUM_ENTRIES-1:0] r_age;
    logic [c_P:0]               r_occ;

    logic [NUM_ENTRIES-1:0]     w_valid_nxt;
    logic [NUM_ENTRIES-1:0]     w_woken_nxt;
    logic [c_W*NUM_ENTRIES-1:0] w_age_nxt;
    logic [c_P:0]               w_occ_nxt;
    logic [c_P-1:0]             w_alloc_ptr;
    logic                       w_alloc_ready;
    logic                       w_alloc_fire;
    logic                       w_sel_hit;
    logic                       w_sel_fire;

    // Lowest-index free entry; scanning downward lets the lowest win.
    always_comb begin
        w_alloc_ptr = '0;
        for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_ptr = c_P'(i);
            end
        end
    end

    assign w_alloc_ready = (r_occ != c_FULL_COUNT);
    assign w_alloc_fire  = alloc_valid_in & w_alloc_ready;
    assign w_sel_hit     = r_valid[select_ptr_in] & r_woken[select_ptr_in];
    assign w_sel_fire    = select_valid_in & w_sel_hit;

    // A freed entry cannot also be the alloc target: alloc_ptr only names invalid entries.
    always_comb begin
        w_valid_nxt = r_valid;
        w_woken_nxt = r_woken;
        w_age_nxt   = r_age;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_sel_fire && (select_ptr_in == c_P'(i))) begin
                w_valid_nxt[i]            = 1'b0;
                w_woken_nxt[i]            = 1'b0;
                w_age_nxt[i*c_W +: c_W]   = '0;
            end else if (w_alloc_fire && (w_alloc_ptr == c_P'(i))) begin
                w_valid_nxt[i]            = 1'b1;
                w_woken_nxt[i]            = 1'b0;
                w_age_nxt[i*c_W +: c_W]   = '0;
            end else if (r_valid[i]) begin
                if (wakeup_in[i]) begin
                    w_woken_nxt[i] = 1'b1;
                end
                if (r_age[i*c_W +: c_W] != c_AGE_MAX) begin
                    w_age_nxt[i*c_W +: c_W] = r_age[i*c_W +: c_W] + c_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_alloc_fire, w_sel_fire})
            2'b10:   w_occ_nxt = r_occ + (c_P+1)'(1);
            2'b01:   w_occ_nxt = r_occ - (c_P+1)'(1);
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_valid <= '0;
            r_woken <= '0;
            r_cond  <= '0;
            r_age   <= '0;
            r_occ   <= '0;
        end else if (flush_in) begin
            r_valid <= '0;
            r_woken <= '0;
            r_cond  <= '0;
            r_age   <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_woken <= w_woken_nxt;
            r_cond  <= w_valid_nxt & w_woken_nxt;
            r_age   <= w_age_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

`ifdef ISSUE_AGE_TRACKER_ERROR_CHECK_EN
    logic r_error;

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_error <= 1'b0;
        end else if ((alloc_valid_in && !w_alloc_ready) ||
                     (select_valid_in && !w_sel_hit)) begin
            r_error <= 1'b1;
        end
    end

    assign error_out = r_error;
`else
    // No error tracking in this build.
`endif

    assign alloc_ready_out = w_alloc_ready;
    assign alloc_ptr_out   = w_alloc_ptr;
    assign condition_out   = r_cond;
    assign elements_out    = r_age;
    assign occupancy_out   = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_issue_age_tracker.sv
// ============================================================================
// Module   : tb_issue_age_tracker
// Brief    : Directed self-checking bench for issue_age_tracker (8 entries).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_age_tracker;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [2:0]  alloc_ptr;
    logic [7:0]  wakeup;
    logic        select_valid;
    logic [2:0]  select_ptr;
    logic [7:0]  condition;
    logic [23:0] elements;
    logic [3:0]  occupancy;
`ifdef ISSUE_AGE_TRACKER_ERROR_CHECK_EN
    logic        error;
`endif

    int checks   = 0;
    int failures = 0;

    issue_age_tracker #(
        .NUM_ENTRIES                  (8),
        .ENTRY_PTR_SIZE_IN_BITS       (3),
        .SINGLE_ELEMENT_WIDTH_IN_BITS (3)
    ) u_dut (
        .clk_in          (clk),
        .reset_in        (rst),
        .flush_in        (flush),
        .alloc_valid_in  (alloc_valid),
        .alloc_ready_out (alloc_ready),
        .alloc_ptr_out   (alloc_ptr),
        .wakeup_in       (wakeup),
        .select_valid_in (select_valid),
        .select_ptr_in   (select_ptr),
        .condition_out   (condition),
        .elements_out    (elements),
        .occupancy_out   (occupancy)
`ifdef ISSUE_AGE_TRACKER_ERROR_CHECK_EN
        ,
        .error_out       (error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        wakeup       = 8'h00;
        select_valid = 1'b0;
        select_ptr   = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", {31'd0, alloc_ready}, 32'd1);
        chk("rst_ptr",   {29'd0, alloc_ptr},   32'd0);
        chk("rst_cond",  {24'd0, condition},   32'd0);
        chk("rst_elem",  {8'd0, elements},     32'd0);
        chk("rst_occ",   {28'd0, occupancy},   32'd0);

        // Three consecutive allocations
        alloc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("alloc_ptr_%0d", i), {29'd0, alloc_ptr}, i);
            tick();
        end
        alloc_valid = 1'b0;
        chk("occ_3",     {28'd0, occupancy}, 32'd3);
        chk("ages_210",  {8'd0, elements},   32'h00000A);

        // Fill entries 3..7, watching entry 5 start at age 0 then 1
        alloc_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("e5_age0", {29'd0, elements[17:15]}, 32'd0);
        tick();
        chk("e5_age1", {29'd0, elements[17:15]}, 32'd1);
        tick();
        chk("occ_8",      {28'd0, occupancy},   32'd8);
        chk("full_ready", {31'd0, alloc_ready}, 32'd0);
        chk("full_ptr",   {29'd0, alloc_ptr},   32'd0);
        tick();
        chk("occ_ovf",    {28'd0, occupancy},   32'd8);
`ifdef ISSUE_AGE_TRACKER_ERROR_CHECK_EN
        chk("err_full",   {31'd0, error},       32'd1);
`endif
        alloc_valid = 1'b0;

        // Age saturation
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("e5_nowrap_%0d", i), {31'd0, (elements[17:15] != 3'd0)}, 32'd1);
        end
        chk("e5_sat",   {29'd0, elements[17:15]}, 32'd7);
        chk("all_sat",  {8'd0, elements},         32'hFFFFFF);

        // Wake entries 0 and 2, free 0
        wakeup = 8'h05;
        tick();
        wakeup = 8'h00;
        chk("cond_05",  {24'd0, condition}, 32'h05);
        select_valid = 1'b1;
        select_ptr   = 3'd0;
        tick();
        chk("cond_04",  {24'd0, condition}, 32'h04);
        chk("occ_7",    {28'd0, occupancy}, 32'd7);
        chk("ptr_free0",{29'd0, alloc_ptr}, 32'd0);

        // Select 2 with concurrent alloc: alloc must land on 0, not 2
        select_ptr  = 3'd2;
        alloc_valid = 1'b1;
        tick();
        select_valid = 1'b0;
        alloc_valid  = 1'b0;
        chk("cond_sel2",  {24'd0, condition},      32'h00);
        chk("occ_same",   {28'd0, occupancy},      32'd7);
        chk("e0_new_age", {29'd0, elements[2:0]},  32'd0);
        chk("e2_cleared", {29'd0, elements[8:6]},  32'd0);
        chk("ptr_next2",  {29'd0, alloc_ptr},      32'd2);

        // Wakeup and select of entry 4 together: select ignored
        wakeup       = 8'h10;
        select_valid = 1'b1;
        select_ptr   = 3'd4;
        tick();
        wakeup = 8'h00;
        chk("cond_10",   {24'd0, condition}, 32'h10);
        chk("occ_keep7", {28'd0, occupancy}, 32'd7);
        tick();
        chk("cond_sel4", {24'd0, condition}, 32'h00);
        chk("occ_6",     {28'd0, occupancy}, 32'd6);
        select_ptr = 3'd2;
        tick();
        select_valid = 1'b0;
        chk("sel_inval", {28'd0, occupancy}, 32'd6);

        // Flush with 6 valid entries and concurrent traffic
        flush        = 1'b1;
        alloc_valid  = 1'b1;
        wakeup       = 8'hFF;
        select_valid = 1'b1;
        select_ptr   = 3'd1;
        tick();
        idle_inputs();
        chk("fl_occ",   {28'd0, occupancy},   32'd0);
        chk("fl_ready", {31'd0, alloc_ready}, 32'd1);
        chk("fl_ptr",   {29'd0, alloc_ptr},   32'd0);
        chk("fl_cond",  {24'd0, condition},   32'd0);
        chk("fl_elem",  {8'd0, elements},     32'd0);

        // Reset pulse mid-sequence
        alloc_valid = 1'b1;
        tick();
        tick();
        chk("pre_rst_occ", {28'd0, occupancy}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_occ",  {28'd0, occupancy}, 32'd0);
        chk("ar_elem", {8'd0, elements},   32'd0);
        chk("ar_ptr",  {29'd0, alloc_ptr}, 32'd0);
        alloc_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_occ",   {28'd0, occupancy},   32'd0);
        chk("post_rst_ready", {31'd0, alloc_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/issue_age_tracker.md
ISSUE_AGE_TRACKER -- requirements
Module: issue_age_tracker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of tracked entries; power of two, 1..16.
REQ-002 SHALL have parameter ENTRY_PTR_SIZE_IN_BITS, default 3: entry index width, equal to log2(NUM_ENTRIES).
REQ-003 SHALL have parameter SINGLE_ELEMENT_WIDTH_IN_BITS, default 3: per-entry age width.
REQ-004 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush_in  input  1  synchronous clear of all entries.
REQ-007 SHALL have port alloc_valid_in  input  1  allocation request.
REQ-008 SHALL have port alloc_ready_out  output  1  at least one free entry exists.
REQ-009 SHALL have port alloc_ptr_out  output  ENTRY_PTR_SIZE_IN_BITS  lowest-index free entry.
REQ-010 SHALL have port wakeup_in  input  NUM_ENTRIES  per-entry "operands ready" strobe.
REQ-011 SHALL have port select_valid_in  input  1  selector has chosen an entry.
REQ-012 SHALL have port select_ptr_in  input  ENTRY_PTR_SIZE_IN_BITS  chosen entry index.
REQ-013 SHALL have port condition_out  output  NUM_ENTRIES  bit i = entry i valid AND woken.
REQ-014 SHALL have port elements_out  output  SINGLE_ELEMENT_WIDTH_IN_BITS*NUM_ENTRIES  packed ages, entry i at bits [(i+1)*W-1 : i*W].
REQ-015 SHALL have port occupancy_out  output  ENTRY_PTR_SIZE_IN_BITS+1  count of valid entries.

Function
REQ-016 SHALL hold per entry: valid bit, woken bit, age register of SINGLE_ELEMENT_WIDTH_IN_BITS.
REQ-017 SHALL drive alloc_ready_out = occupancy_out != NUM_ENTRIES and alloc_ptr_out = lowest free index (0 when full), both combinational from current state.
REQ-018 SHALL, on alloc_valid_in & alloc_ready_out, set entry alloc_ptr_out valid, woken 0, age 0 at the next edge; alloc_valid_in while full SHALL be ignored.
REQ-019 SHALL increment the age of every valid entry each cycle, saturating at all-ones; an entry allocated this edge SHALL read age 0, then 1 one cycle later.
REQ-020 SHALL set woken for entry i when wakeup_in[i] is high and entry i is valid; wakeup on an invalid entry SHALL be ignored; woken stays set until entry freed.
REQ-021 SHALL, on select_valid_in with select_ptr_in naming a valid woken entry, clear valid, woken and age of that entry at the next edge (condition_out bit low one cycle after select).
REQ-022 SHALL ignore select_valid_in naming an entry that is invalid or not woken.
REQ-023 SHALL give free priority over wakeup when both target the same entry in one cycle.
REQ-024 SHALL not allow an entry freed at an edge to be allocated at that same edge (alloc_ptr_out reflects pre-edge state).
REQ-025 SHALL update occupancy_out +1 on alloc only, -1 on accepted select only, unchanged on both.
REQ-026 SHALL, on flush_in, clear all valid, woken and age bits and occupancy at the next edge, overriding alloc, wakeup and select in that cycle.
REQ-027 SHALL drive elements_out and condition_out directly from registers (zero combinational input-to-output path).

Reset
REQ-028 SHALL, while reset_in is high, asynchronously clear all valid, woken, age state and occupancy.
REQ-029 SHALL present after reset: alloc_ready_out 1, alloc_ptr_out 0, condition_out 0, elements_out 0, occupancy_out 0.
REQ-030 SHALL discard any in-flight alloc, wakeup or select when reset asserts mid-operation.

Configuration
REQ-031 SHALL, when macro ISSUE_AGE_TRACKER_ERROR_CHECK_EN is defined, add output error_out (1 bit) set sticky (cleared only by reset_in) on alloc_valid_in while full or on a select ignored per REQ-022.
REQ-032 SHALL, without ISSUE_AGE_TRACKER_ERROR_CHECK_EN, have no error_out port and no error logic; functional behaviour otherwise identical.

Verification
REQ-033 SHALL cover: reset, then alloc 3 consecutive cycles -> alloc_ptr_out 0,1,2; occupancy_out 3; ages 2,1,0 the cycle after third alloc.
REQ-034 SHALL cover: 8 allocs then alloc_valid_in held -> alloc_ready_out 0, occupancy_out stays 8, ninth alloc ignored (error_out 1 with macro).
REQ-035 SHALL cover: entry 5 held valid 10 cycles -> age saturates at 7, never wraps to 0.
REQ-036 SHALL cover: wakeup_in[2] then select_ptr_in 2 with alloc in same cycle -> condition_out[2] low next cycle, occupancy unchanged, new entry not index 2.
REQ-037 SHALL cover: wakeup_in[4] and select_ptr_in 4 same cycle, entry 4 not previously woken -> select ignored, entry 4 woken next cycle.
REQ-038 SHALL cover: flush_in with 6 valid entries plus concurrent alloc -> all outputs return to reset values next cycle; reset_in pulse mid-sequence -> immediate reset values.
